// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch unit and the decoder.
// Holds the fetch FSM states, jump-target field widths and jump opcodes.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // Jump target = {pc4[31:28], index[25:0], 2'b00}
    localparam int JT_HI_W  = 4;
    localparam int JT_IDX_W = 26;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

endpackage

// File: rtl/ifetch32_if.sv
// Instruction memory request/acknowledge port.
// The master issues word addresses; the slave returns data with ack.
interface ifetch32_if #(
    parameter int AW = 14
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_npc.sv
// Next-PC selection for the issued instruction.
// Priority: Jr, then Jmp/Jal, then taken branch, then fall-through.
module ifetch_npc
    import cpu_pkg::*;
(
    input  logic [31:0]         opcplus4,
    input  logic [JT_IDX_W-1:0] instr_index,
    input  logic                Branch,
    input  logic                nBranch,
    input  logic                Jmp,
    input  logic                Jal,
    input  logic                Jr,
    input  logic                Zero,
    input  logic [31:0]         Addr_result,
    input  logic [31:0]         Read_data_1,
    output logic [31:0]         next_pc,
    output logic                misaligned
);
    logic taken;

    assign taken = (Branch & Zero) | (nBranch & ~Zero);

    // Priority mux; overlapping controls resolve silently.
    always_comb begin
        next_pc = opcplus4;
        if (Jr) begin
            next_pc = Read_data_1;
        end else if (Jmp | Jal) begin
            next_pc = {opcplus4[31:32-JT_HI_W], instr_index, 2'b00};
        end else if (taken) begin
            next_pc = Addr_result;
        end
    end

    assign misaligned = |next_pc[1:0];
endmodule

// File: rtl/ifetch32.sv
// Instruction fetch unit: owns the PC and runs a FETCH/ISSUE loop.
// A misaligned next PC parks the unit in FAULT until reset.
module ifetch32
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    ifetch32_if.master         imem,
    output logic [31:0]        Instruction,
    output logic [31:0]        opcplus4,
    output logic               inst_valid,
    input  logic               inst_ready,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jr,
    input  logic               Zero,
    input  logic [31:0]        Addr_result,
    input  logic [31:0]        Read_data_1,
    output logic               fault
);
    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  instr_q;
    logic [31:0]  opc4_q;
    logic         valid_q;
    logic         fault_q;
    logic         misaligned;

    ifetch_npc u_npc (
        .opcplus4    (opc4_q),
        .instr_index (instr_q[JT_IDX_W-1:0]),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Zero        (Zero),
        .Addr_result (Addr_result),
        .Read_data_1 (Read_data_1),
        .next_pc     (pc_d),
        .misaligned  (misaligned)
    );

    // FSM with registered outputs; reset discards any pending ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            opc4_q  <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        opc4_q  <= pc_q + 32'd4;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (inst_ready) begin
                        valid_q <= 1'b0;
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = (state_q == FETCH) & ~rst;
    assign imem.imem_addr = pc_q[IMEM_AW+1:2];
    assign Instruction    = instr_q;
    assign opcplus4       = opc4_q;
    assign inst_valid     = valid_q;
    assign fault          = fault_q;
endmodule
